// File: rtl/ysyx_25030081_div_pkg.sv
// Shared encodings and helpers for the iterative RV32M divider.
package ysyx_25030081_div_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned DIV_ITER = 32;
    localparam int unsigned CNT_W    = 6;

    typedef enum logic [1:0] {
        DIV_OP_DIV  = 2'b00,
        DIV_OP_DIVU = 2'b01,
        DIV_OP_REM  = 2'b10,
        DIV_OP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10
    } div_state_e;

    function automatic logic [XLEN-1:0] neg32(input logic [XLEN-1:0] x);
        return ~x + XLEN'(1);
    endfunction

endpackage

// File: rtl/ysyx_25030081_clz32.sv
// Combinational leading-zero counter; an all-zero input reports 32.
module ysyx_25030081_clz32
    import ysyx_25030081_div_pkg::*;
(
    input  logic [31:0] data,
    output logic [5:0]  cnt
);

    logic found;

    always_comb begin
        cnt   = '0;
        found = 1'b0;
        for (int i = 31; i >= 0; i--) begin
            if (!found) begin
                if (data[i]) begin
                    found = 1'b1;
                end else begin
                    cnt = cnt + 6'd1;
                end
            end
        end
    end

endmodule

// File: rtl/ysyx_25030081_div.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU with valid/ready handshakes.
// Define YSYX_25030081_DIV_EARLY_EN to skip the dividend's leading zeros.
module ysyx_25030081_div
    import ysyx_25030081_div_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            op,
    input  logic [DATA_WIDTH-1:0] op1,
    input  logic [DATA_WIDTH-1:0] op2,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out
);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  rem_q, rem_d;
    logic [XLEN-1:0]  quot_q, quot_d;
    logic [XLEN-1:0]  dvsr_q, dvsr_d;
    logic             is_rem_q, is_rem_d;
    logic             quot_neg_q, quot_neg_d;
    logic             rem_neg_q, rem_neg_d;
    logic [XLEN-1:0]  out_d;
    logic             out_valid_d;
    logic             in_ready_d;

    logic             sgn;
    logic [XLEN-1:0]  a_mag;
    logic [XLEN-1:0]  b_mag;
    logic             div_zero;
    logic             div_ovf;
    logic [XLEN-1:0]  special_res;
    logic [XLEN:0]    trial;

`ifdef YSYX_25030081_DIV_EARLY_EN
    logic [5:0] lz;

    ysyx_25030081_clz32 u_clz (
        .data (a_mag),
        .cnt  (lz)
    );
`endif

    // Request decode: magnitudes and the two results that bypass iteration
    always_comb begin
        sgn      = (op == DIV_OP_DIV) || (op == DIV_OP_REM);
        a_mag    = (sgn && op1[XLEN-1]) ? neg32(op1) : op1;
        b_mag    = (sgn && op2[XLEN-1]) ? neg32(op2) : op2;
        div_zero = (op2 == '0);
        div_ovf  = sgn && (op1 == 32'h8000_0000) && (op2 == 32'hFFFF_FFFF);
        if (op[1]) begin
            special_res = div_zero ? op1 : '0;
        end else begin
            special_res = div_zero ? 32'hFFFF_FFFF : 32'h8000_0000;
        end
    end

    // One restoring step: shifted remainder minus divisor, sign bit decides
    assign trial = {rem_q, quot_q[XLEN-1]} - {1'b0, dvsr_q};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quot_d      = quot_q;
        dvsr_d      = dvsr_q;
        is_rem_d    = is_rem_q;
        quot_neg_d  = quot_neg_q;
        rem_neg_d   = rem_neg_q;
        out_d       = out;
        out_valid_d = out_valid;
        in_ready_d  = in_ready;

        unique case (state_q)
            ST_IDLE: begin
                if (in_valid && !flush) begin
                    is_rem_d   = op[1];
                    quot_neg_d = sgn && (op1[XLEN-1] ^ op2[XLEN-1]);
                    rem_neg_d  = sgn && op1[XLEN-1];
                    dvsr_d     = b_mag;
                    in_ready_d = 1'b0;
                    if (div_zero || div_ovf) begin
                        out_d       = special_res;
                        out_valid_d = 1'b1;
                        state_d     = ST_DONE;
`ifdef YSYX_25030081_DIV_EARLY_EN
                    end else if (a_mag == '0) begin
                        out_d       = '0;
                        out_valid_d = 1'b1;
                        state_d     = ST_DONE;
`endif
                    end else begin
                        rem_d   = '0;
                        state_d = ST_CALC;
`ifdef YSYX_25030081_DIV_EARLY_EN
                        quot_d  = a_mag << lz;
                        cnt_d   = CNT_W'(DIV_ITER) - lz;
`else
                        quot_d  = a_mag;
                        cnt_d   = CNT_W'(DIV_ITER);
`endif
                    end
                end
            end
            ST_CALC: begin
                if (cnt_q != '0) begin
                    if (!trial[XLEN]) begin
                        rem_d  = trial[XLEN-1:0];
                        quot_d = {quot_q[XLEN-2:0], 1'b1};
                    end else begin
                        rem_d  = {rem_q[XLEN-2:0], quot_q[XLEN-1]};
                        quot_d = {quot_q[XLEN-2:0], 1'b0};
                    end
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    if (is_rem_q) begin
                        out_d = rem_neg_q ? neg32(rem_q) : rem_q;
                    end else begin
                        out_d = quot_neg_q ? neg32(quot_q) : quot_q;
                    end
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
            end
        endcase

        // A redirect kills whatever is in flight, including an unconsumed result
        if (flush && (state_q != ST_IDLE)) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            rem_q      <= '0;
            quot_q     <= '0;
            dvsr_q     <= '0;
            is_rem_q   <= 1'b0;
            quot_neg_q <= 1'b0;
            rem_neg_q  <= 1'b0;
            out        <= '0;
            out_valid  <= 1'b0;
            in_ready   <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            quot_q     <= quot_d;
            dvsr_q     <= dvsr_d;
            is_rem_q   <= is_rem_d;
            quot_neg_q <= quot_neg_d;
            rem_neg_q  <= rem_neg_d;
            out        <= out_d;
            out_valid  <= out_valid_d;
            in_ready   <= in_ready_d;
        end
    end

endmodule

// File: tb/tb_ysyx_25030081_div.sv
// Randomized self-checking bench for ysyx_25030081_div against an arithmetic model.
module tb_ysyx_25030081_div;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out;

    int n_checks = 0;
    int n_errors = 0;

    ysyx_25030081_div dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .op1       (op1),
        .op2       (op2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // RV32M semantics straight from the instruction definitions
    function automatic logic [31:0] ref_div(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = a;
        sb = b;
        if (b == 0) return o[1] ? a : 32'hFFFF_FFFF;
        if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'h0 : 32'h8000_0000;
        case (o)
            2'b00:   return sa / sb;
            2'b01:   return a / b;
            2'b10:   return sa % sb;
            default: return a % b;
        endcase
    endfunction

    function automatic int exp_lat(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] mag;
        int          lz;
        if (b == 0) return 1;
        if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        mag = (!o[0] && a[31]) ? -a : a;
        lz  = 32;
        for (int i = 31; i >= 0; i--) begin
            if (mag[i]) begin
                lz = 31 - i;
                break;
            end
        end
`ifdef YSYX_25030081_DIV_EARLY_EN
        if (mag == 0) return 1;
        return 34 - lz;
`else
        return (lz > 40) ? 0 : 34;
`endif
    endfunction

    // Issue one request, wait for the result, optionally stall the consumer, then drain
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int stall);
        int          lat;
        int          w;
        logic [31:0] held;
        logic        held_ok;
        w = 0;
        while (!in_ready && w < 100) begin
            @(posedge clk); #1;
            w++;
        end
        if (!in_ready) check({tag, "/in_ready_timeout"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        op       = o;
        op1      = a;
        op2      = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        op       = 2'($urandom);
        op1      = $urandom;
        op2      = $urandom;
        lat      = 1;
        while (!out_valid && lat < 80) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) begin
            check({tag, "/timeout"}, 32'(out_valid), 32'd1);
            return;
        end
        check({tag, "/res"}, out, exp);
        check({tag, "/lat"}, 32'(lat), 32'(exp_lat(o, a, b)));
        if (stall > 0) begin
            held    = out;
            held_ok = 1'b1;
            for (int i = 0; i < stall; i++) begin
                @(posedge clk); #1;
                if (out !== held || out_valid !== 1'b1 || in_ready !== 1'b0) held_ok = 1'b0;
            end
            check({tag, "/hold"}, 32'(held_ok), 32'd1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "/drain"}, {30'd0, out_valid, in_ready}, 32'd1);
    endtask

    initial begin
        logic        seen;
        logic [1:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;

        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op        = 2'b00;
        op1       = '0;
        op2       = '0;
        #12;
        check("rst_state", {out_valid, in_ready, out[29:0]}, 32'h4000_0000);
        #11;
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("divu_100_7", 2'b01, 32'd100, 32'd7, 32'd14, 0);
        run_op("remu_100_7", 2'b11, 32'd100, 32'd7, 32'd2, 0);
        run_op("div_m100_7", 2'b00, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 0);
        run_op("rem_m100_7", 2'b10, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 0);
        run_op("divu_dz", 2'b01, 32'd5, 32'd0, 32'hFFFF_FFFF, 0);
        run_op("rem_dz", 2'b10, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 0);
        run_op("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
        run_op("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 0);
        run_op("divu_zero_dvd", 2'b01, 32'd0, 32'd5, 32'd0, 0);
        run_op("div_min_2", 2'b00, 32'h8000_0000, 32'd2, 32'hC000_0000, 0);
        run_op("divu_stall", 2'b01, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 10);

        // Flush ten cycles into a long divide
        in_valid = 1'b1;
        op = 2'b01; op1 = 32'hFFFF_0000; op2 = 32'd3;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_calc", {30'd0, out_valid, in_ready}, 32'd1);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        check("flush_no_result", 32'(seen), 32'd0);

        // Flush while idle holds off acceptance
        flush = 1'b1; in_valid = 1'b1;
        op = 2'b01; op1 = 32'd9; op2 = 32'd0;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;
        check("flush_idle", {30'd0, out_valid, in_ready}, 32'd1);

        // Asynchronous reset in the middle of a divide
        in_valid = 1'b1;
        op = 2'b00; op1 = 32'h7654_3210; op2 = 32'd13;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst", {30'd0, out_valid, in_ready}, 32'd1);
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op("after_rst", 2'b11, 32'd1000, 32'd33, 32'd10, 0);

        for (int n = 0; n < 1000; n++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 9))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: ra = 32'd0;
                3: rb = 32'($urandom_range(1, 20));
                4: begin ra = 32'($urandom_range(0, 255)); rb = 32'($urandom_range(1, 9)); end
                5: rb = -32'($urandom_range(1, 20));
                default: ;
            endcase
            run_op("rand", ro, ra, rb, ref_div(ro, ra, rb), $urandom_range(0, 2));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/ysyx_25030081_div.md
Name: ysyx_25030081_div

Overview:
Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU. It is the multi-cycle counterpart to the single-cycle integer ALU in the EXU datapath. It takes an operation and two operands over a valid/ready request interface and returns the 32-bit result over a valid/ready response interface. The EXU stalls on it for divide-class instructions; `flush` lets a redirect kill an in-flight divide.

Parameters:
- DATA_WIDTH, 32, operand/result width; only 32 is supported.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  abort current operation; synchronous
- in_valid  input  1  request valid
- in_ready  output  1  divider can accept a request
- op  input  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU
- op1  input  DATA_WIDTH  dividend
- op2  input  DATA_WIDTH  divisor
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out  output  DATA_WIDTH  quotient (DIV/DIVU) or remainder (REM/REMU)

Behaviour:
- Clock and reset: one clock `clk`. `rst_n` is asynchronous and active-low. Reset forces state IDLE, in_ready=1, out_valid=0, out=0, counter=0.
- States: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - When in_valid&&!flush, latch op and compute magnitudes. Signed ops use |op1| and |op2|; unsigned ops use raw values.
  - Latch quot_neg = signed & (op1[31]^op2[31]) and rem_neg = signed & op1[31].
  - Special cases go straight to DONE on the next edge with a precomputed result:
    - op2==0: quotient 32'hFFFF_FFFF, remainder = op1.
    - Signed op with op1==32'h8000_0000 and op2==32'hFFFF_FFFF: quotient 32'h8000_0000, remainder 0.
  - Otherwise go to CALC with counter=32, partial remainder=0, and quotient register = dividend magnitude.
- CALC:
  - in_ready=0.
  - Each cycle: shift {rem,quot} left by 1, trial-subtract the divisor magnitude from rem (33-bit). If non-negative, keep the difference and set quot[0]=1; else restore and set quot[0]=0. Decrement counter.
  - When the counter reaches 0, apply the sign fix (negate quotient if quot_neg, remainder if rem_neg), register `out`, and go to DONE.
- DONE:
  - out_valid=1, `out` stable.
  - On out_ready, go to IDLE next cycle.
  - There is no same-cycle accept of a new request in DONE (in_ready=0).
- Latency: accept edge to out_valid is 34 cycles for the normal path, 1 cycle for the special-case path.
- Flush:
  - In CALC or DONE: return to IDLE next edge and drop out_valid; the result is lost.
  - In IDLE: blocks acceptance.
  - Flush takes priority over out_ready and in_valid.
- Async reset mid-CALC: immediate return to IDLE; no result is produced.
- out_valid held while !out_ready: `out` must not change.
- Inputs are sampled only on the accept edge. op1/op2 may change afterwards.

Optional Feature:
- Macro: YSYX_25030081_DIV_EARLY_EN.
- With it defined:
  - In IDLE, compute lz = count of leading zeros of the dividend magnitude.
  - Pre-shift the dividend left by lz and load counter = 32-lz.
  - A zero dividend (not divide-by-zero) goes directly to DONE with quotient 0 and remainder 0.
  - Latency becomes 34-lz cycles.
- Without it: the counter is always 32 and the fixed latency is 34 cycles.
- Results must be bit-identical in both builds.

Decomposition:
- Shared package ysyx_25030081_div_pkg holds:
  - op encodings DIV_OP_DIV/DIVU/REM/REMU.
  - State encoding (IDLE/CALC/DONE).
  - DIV_ITER=32.
- One natural sub-module: ysyx_25030081_clz32, a combinational leading-zero counter. It is instantiated only under YSYX_25030081_DIV_EARLY_EN.

Test Plan:
1. DIVU: op1=100, op2=7, out_ready=1 -> out=14 after 34 cycles; REMU with the same operands -> 2.
2. DIV: op1=-100 (32'hFFFF_FF9C), op2=7 -> out=-14 (32'hFFFF_FFF2); REM -> -2 (32'hFFFF_FFFE).
3. Divide by zero: DIVU op1=5, op2=0 -> 32'hFFFF_FFFF after 1 cycle; REM op1=-5, op2=0 -> 32'hFFFF_FFFB.
4. Overflow: DIV op1=32'h8000_0000, op2=32'hFFFF_FFFF -> 32'h8000_0000; REM -> 0; both after 1 cycle.
5. Backpressure and flush:
   - Hold out_ready=0 for 10 cycles after out_valid -> out stable, in_ready=0.
   - Separately, assert flush at CALC cycle 10 -> out_valid never rises, in_ready=1 on the next cycle.
6. Async reset: drop rst_n mid-CALC -> out_valid=0, in_ready=1 immediately. Then 1000 random ops checked against a reference model, in both builds, with and without YSYX_25030081_DIV_EARLY_EN.
